// File: rtl/mult_q_pkg.sv
// rtl/mult_q_pkg.sv - shared types, Q-format constant and saturation helper for mult_q
package mult_q_pkg;

    // Default fractional bit count shared by the Q10 datapath stages
    localparam int QUANT_FRAC_BITS = 10;

    // Widest data path the saturation helper supports
    localparam int Q_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    typedef struct packed {
        logic               ovf;
        logic [Q_MAX_W-1:0] val;
    } sat_t;

    // Clamp a sign-extended wide value into a signed w-bit range.
    // The low w bits of val carry the result; ovf flags a clamp.
    function automatic sat_t sat_q(input logic signed [2*Q_MAX_W-1:0] x, input int w);
        logic signed [2*Q_MAX_W-1:0] hi;
        logic signed [2*Q_MAX_W-1:0] lo;
        sat_t                        r;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (w - 1));
        if (x > hi) begin
            r.ovf = 1'b1;
            r.val = hi[Q_MAX_W-1:0];
        end else if (x < lo) begin
            r.ovf = 1'b1;
            r.val = lo[Q_MAX_W-1:0];
        end else begin
            r.ovf = 1'b0;
            r.val = x[Q_MAX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_q.sv
// rtl/mult_q.sv - iterative shift-add signed Q-format multiplier with saturation
module mult_q
    import mult_q_pkg::*;
#(
    parameter int data_width = 32,
    parameter int FRAC_BITS  = QUANT_FRAC_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid_in,
    output logic                  ready,
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    output logic                  valid_out,
    output logic [data_width-1:0] product,
    output logic                  overflow
);

    localparam int W2 = 2 * data_width;

    state_t                  state_q, state_d;
    logic [W2-1:0]           acc_q, acc_d;
    logic [W2-1:0]           mcand_q, mcand_d;
    logic [data_width-1:0]   mplier_q, mplier_d;
    logic                    sign_q, sign_d;
    logic                    valid_out_q, valid_out_d;
    logic [data_width-1:0]   product_q, product_d;
    logic                    overflow_q, overflow_d;

    // Magnitudes are unsigned, so |-2^(W-1)| = 2^(W-1) fits exactly
    logic [data_width-1:0]   abs_a;
    logic [data_width-1:0]   abs_b;
    logic signed [W2-1:0]    signed_prod;
    logic signed [W2-1:0]    shifted;
    sat_t                    sat_res;

    // Register update; reset clears every piece of state and drops any partial result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            sign_q      <= 1'b0;
            valid_out_q <= 1'b0;
            product_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            sign_q      <= sign_d;
            valid_out_q <= valid_out_d;
            product_q   <= product_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state and datapath: latch magnitudes, one multiplier bit per CALC cycle, sign+round+clamp in FIX
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        sign_d      = sign_q;
        valid_out_d = 1'b0;
        product_d   = product_q;
        overflow_d  = overflow_q;

        abs_a = a[data_width-1] ? (~a + data_width'(1)) : a;
        abs_b = b[data_width-1] ? (~b + data_width'(1)) : b;

        // Accumulator never exceeds 2^(2W-2), so negation cannot wrap
        signed_prod = sign_q ? -$signed(acc_q) : $signed(acc_q);
        shifted     = signed_prod >>> FRAC_BITS;
        sat_res     = sat_q((2*Q_MAX_W)'(shifted), data_width);

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    mcand_d  = {{data_width{1'b0}}, abs_a};
                    mplier_d = abs_b;
                    sign_d   = a[data_width-1] ^ b[data_width-1];
                    acc_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                // Stops as soon as the remaining multiplier bits are all zero
                if (mplier_q == '0) begin
                    state_d = FIX;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
            end
            FIX: begin
                product_d   = sat_res.val[data_width-1:0];
                overflow_d  = sat_res.ovf;
                valid_out_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: ready is decoded from state so it rises together with the result pulse
    always_comb begin
        ready     = (state_q == IDLE);
        valid_out = valid_out_q;
        product   = product_q;
        overflow  = overflow_q;
    end

    // Upper bits of the clamped value are not needed when the data path is narrower than the helper
    if (data_width < Q_MAX_W) begin : g_sat_hi
        logic unused_sat_hi;
        assign unused_sat_hi = ^sat_res.val[Q_MAX_W-1:data_width];
    end

endmodule

// File: tb/tb_mult_q.sv
// tb/tb_mult_q.sv - randomized self-checking bench for mult_q against an arithmetic model
module tb_mult_q;

    logic        clock;
    logic        reset;
    logic        valid_in;
    logic        ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        valid_out;
    logic [31:0] product;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    mult_q #(.data_width(32), .FRAC_BITS(10)) dut (
        .clock    (clock),
        .reset    (reset),
        .valid_in (valid_in),
        .ready    (ready),
        .a        (a),
        .b        (b),
        .valid_out(valid_out),
        .product  (product),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: full-precision signed product, floor shift, clamp; latency from MSB of |b|
    function automatic void model(input logic [31:0] ta, input logic [31:0] tb_,
                                  output logic [31:0] p, output logic ovf, output int lat);
        longint full;
        longint s;
        longint mag;
        int     msb;
        full = longint'($signed(ta)) * longint'($signed(tb_));
        s    = full >>> 10;
        if (s > 64'sd2147483647) begin
            p = 32'h7FFF_FFFF; ovf = 1'b1;
        end else if (s < -64'sd2147483648) begin
            p = 32'h8000_0000; ovf = 1'b1;
        end else begin
            p = s[31:0]; ovf = 1'b0;
        end
        mag = longint'($signed(tb_));
        if (mag < 0) mag = -mag;
        msb = -1;
        for (int i = 0; i < 40; i++) if (mag[i]) msb = i;
        lat = (msb < 0) ? 2 : msb + 3;
    endfunction

    // Count edges until valid_out; optionally scramble operands while busy
    task automatic wait_valid(output int lat, input bit jitter);
        lat = -1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clock); #1;
            if (valid_out) begin
                lat = k;
                break;
            end
            if (jitter) begin
                a = $urandom;
                b = $urandom;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] ta, input logic [31:0] tb_, input int lat);
        logic [31:0] ep;
        logic        eo;
        int          el;
        model(ta, tb_, ep, eo, el);
        check({tag, ".lat"}, 64'(lat), 64'(el));
        check({tag, ".prod"}, 64'(product), 64'(ep));
        check({tag, ".ovf"}, 64'(overflow), 64'(eo));
    endtask

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_);
        int lat;
        @(negedge clock);
        check({tag, ".ready"}, 64'(ready), 64'd1);
        valid_in = 1'b1; a = ta; b = tb_;
        @(posedge clock); #1;
        valid_in = 1'b0;
        wait_valid(lat, 1'b0);
        check_result(tag, ta, tb_, lat);
        if (lat > 0) begin
            @(posedge clock); #1;
            check({tag, ".pulse"}, 64'(valid_out), 64'd0);
        end
    endtask

    initial begin
        int          lat;
        int          seen;
        logic [31:0] ra, rb;
        logic [31:0] p1a, p1b, p2a, p2b;

        reset = 1'b1; valid_in = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst.ready", 64'(ready), 64'd1);
        check("rst.valid", 64'(valid_out), 64'd0);
        check("rst.prod", 64'(product), 64'd0);
        check("rst.ovf", 64'(overflow), 64'd0);
        @(negedge clock); reset = 1'b0;

        run_op("basic", 32'h0000_0C00, 32'h0000_0400);
        run_op("mixed", 32'hFFFF_F400, 32'h0000_0600);
        run_op("floor_neg", 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("floor_pos", 32'h0000_0001, 32'h0000_0001);
        run_op("bzero", 32'h1234_5678, 32'h0000_0000);
        run_op("azero_neg", 32'h0000_0000, 32'hFFFF_FC00);
        run_op("bmin", 32'h0000_0400, 32'h8000_0000);
        run_op("sat_pos", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_op("sat_neg", 32'h8000_0000, 32'h7FFF_FFFF);
        run_op("min_min", 32'h8000_0000, 32'h8000_0000);

        for (int i = 0; i < 40; i++) begin
            ra = 32'($signed($urandom) >>> $urandom_range(0, 31));
            rb = 32'($signed($urandom) >>> $urandom_range(0, 31));
            run_op($sformatf("rnd%0d", i), ra, rb);
        end

        // Operands held valid while busy: only the first pair counts, second taken on the result cycle
        p1a = 32'h0000_1800; p1b = 32'hFFFF_E000;
        p2a = 32'hFFFF_FA00; p2b = 32'h0000_0A00;
        @(negedge clock);
        valid_in = 1'b1; a = p1a; b = p1b;
        @(posedge clock); #1;
        wait_valid(lat, 1'b1);
        a = p2a; b = p2b;
        check_result("hs1", p1a, p1b, lat);
        check("hs1.ready", 64'(ready), 64'd1);
        @(posedge clock); #1;
        valid_in = 1'b0;
        check("hs2.busy", 64'(ready), 64'd0);
        wait_valid(lat, 1'b0);
        check_result("hs2", p2a, p2b, lat);
        @(posedge clock); #1;

        // Reset during CALC discards the operation; product has a nonzero value beforehand
        @(negedge clock);
        valid_in = 1'b1; a = 32'h0000_7C00; b = 32'h8000_0000;
        @(posedge clock); #1;
        valid_in = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("midrst.ready", 64'(ready), 64'd1);
        check("midrst.valid", 64'(valid_out), 64'd0);
        check("midrst.prod", 64'(product), 64'd0);
        check("midrst.ovf", 64'(overflow), 64'd0);
        @(negedge clock); reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (valid_out) seen++;
        end
        check("midrst.novalid", 64'(seen), 64'd0);

        run_op("post_rst", 32'hFFFF_FC00, 32'hFFFF_F800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
